// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (zero/sign/upper/branch) with a valid/ready skid buffer.
// Optional IMM_EXT_STATS_EN adds ext_count/neg_count transfer counters.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [15:0]      ext_count,
  output logic [15:0]      neg_count
`endif
);

  localparam int unsigned PadW = OUT_W - IN_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [OUT_W-1:0] oreg_q, sreg_q;
  logic [OUT_W-1:0] sext, ext;
  logic             accept, drain;
  logic             load_o, load_s, shift_s;

  always_comb begin
    sext = {{PadW{in_imm[IN_W-1]}}, in_imm};
    unique case (in_mode)
      2'b00:   ext = {{PadW{1'b0}}, in_imm};
      2'b01:   ext = sext;
      2'b10:   ext = {in_imm, {PadW{1'b0}}};
      default: ext = sext << 2;
    endcase
  end

  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = oreg_q;

  always_comb begin
    state_d = state_q;
    load_o  = 1'b0;
    load_s  = 1'b0;
    shift_s = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          load_o  = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          load_o = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          shift_s = 1'b1;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      oreg_q     <= '0;
      sreg_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
      if (load_o) begin
        oreg_q <= ext;
      end else if (shift_s) begin
        oreg_q <= sreg_q;
      end
      if (load_s) begin
        sreg_q <= ext;
      end
    end
  end

`ifdef IMM_EXT_STATS_EN
  // Negative-input flag travels with each entry so it is counted when the entry drains.
  logic        neg_in, oneg_q, sneg_q;
  logic [15:0] ext_count_q, neg_count_q;

  assign neg_in    = in_mode[0] && in_imm[IN_W-1];
  assign ext_count = ext_count_q;
  assign neg_count = neg_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oneg_q      <= 1'b0;
      sneg_q      <= 1'b0;
      ext_count_q <= '0;
      neg_count_q <= '0;
    end else begin
      if (load_o) begin
        oneg_q <= neg_in;
      end else if (shift_s) begin
        oneg_q <= sneg_q;
      end
      if (load_s) begin
        sneg_q <= neg_in;
      end
      if (drain) begin
        ext_count_q <= ext_count_q + 16'd1;
        neg_count_q <= neg_count_q + {15'd0, oneg_q};
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed mode/handshake cases plus randomized traffic.
module tb_imm_extend_pipe;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_STATS_EN
  logic [15:0]      ext_count, neg_count;
`endif

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef IMM_EXT_STATS_EN
    ,
    .ext_count (ext_count),
    .neg_count (neg_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned      n_cmp = 0;
  int unsigned      n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic             bp_rand = 1'b0;

  initial begin
    if (OUT_W < IN_W + 2) begin
      $display("FAIL param_check OUT_W=%0d is below required IN_W+2=%0d", OUT_W, IN_W + 2);
      $fatal(1);
    end
  end

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: extension computed as integer arithmetic on the immediate's value.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    longint v, s, r;
    v = longint'(imm);
    s = (v >= (longint'(1) << (IN_W - 1))) ? v - (longint'(1) << IN_W) : v;
    case (mode)
      2'd0:    r = v;
      2'd1:    r = s;
      2'd2:    r = v * (longint'(1) << (OUT_W - IN_W));
      default: r = s * 4;
    endcase
    return r[OUT_W-1:0];
  endfunction

  // Monitor: every output transfer is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", out_data, '0);
        if (out_data == '0) begin
          n_err++;
          $display("FAIL unexpected_output: got 0x%08h, expected none", out_data);
        end
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (bp_rand) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Presents one item and holds it until accepted; callers start at posedge+1.
  task automatic send(input logic [IN_W-1:0] imm, input logic [1:0] mode,
                      input logic [OUT_W-1:0] exp);
    logic acc;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(exp);
        return;
      end
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_imm   = $urandom();
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", OUT_W'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_out_valid", OUT_W'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", OUT_W'(in_ready), 1);
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("idle_out_valid", OUT_W'(out_valid), 0);
    end

    // Directed modes, out_ready high
    send(16'h8001, 2'b00, 32'h0000_8001);
    send(16'h8001, 2'b01, 32'hFFFF_8001);
    send(16'h7FFF, 2'b01, 32'h0000_7FFF);
    send(16'h1234, 2'b10, 32'h1234_0000);
    send(16'hFFFF, 2'b11, 32'hFFFF_FFFC);
    send(16'h0004, 2'b11, 32'h0000_0010);
    idle();
    wait_drained();

    // Asynchronous reset while holding data
    out_ready = 1'b0;
    send(16'h0055, 2'b00, 32'h0000_0055);
    idle();
    do_reset();
    out_ready = 1'b1;

    // Backpressure: two accepted, third held, then a gap-free drain
    out_ready = 1'b0;
    send(16'h0001, 2'b00, 32'h0000_0001);
    send(16'h0002, 2'b00, 32'h0000_0002);
    fork
      send(16'h0003, 2'b00, 32'h0000_0003);
      begin
        chk("bp_in_ready_low", OUT_W'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_held", OUT_W'(in_ready), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_no_gap", OUT_W'(out_valid), 1);
        end
      end
    join
    idle();
    wait_drained();

    // Streaming: 8 back-to-back with 1-cycle latency
    fork
      for (int i = 0; i < 8; i++) send(16'(16'h0100 + i), 2'b00, OUT_W'(32'h0100 + i));
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("stream_out_valid", OUT_W'(out_valid), 1);
          chk("stream_in_ready", OUT_W'(in_ready), 1);
        end
      end
    join
    idle();
    wait_drained();

    // Reset while FULL, then no stale data ahead of the next item
    out_ready = 1'b0;
    send(16'h0AAA, 2'b01, 32'h0000_0AAA);
    send(16'h0BBB, 2'b01, 32'h0000_0BBB);
    idle();
    do_reset();
    out_ready = 1'b1;
    send(16'h00FF, 2'b00, 32'h0000_00FF);
    idle();
    wait_drained();

    // Randomized traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [IN_W-1:0] imm;
      logic [1:0]      mode;
      imm  = IN_W'($urandom());
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      send(imm, mode, model(imm, mode));
    end
    idle();
    bp_rand = 1'b0;
    #2 out_ready = 1'b1;
    wait_drained();

`ifdef IMM_EXT_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h8000, 2'b01, 32'hFFFF_8000);
    idle();
    wait_drained();
    chk("ext_count_4", OUT_W'(ext_count), 4);
    chk("neg_count_4", OUT_W'(neg_count), 4);
    for (int i = 4; i < 65535; i++) send(16'(i), 2'b00, OUT_W'(i));
    idle();
    wait_drained();
    chk("ext_count_ffff", OUT_W'(ext_count), 32'h0000_FFFF);
    send(16'h0001, 2'b00, 32'h0000_0001);
    idle();
    wait_drained();
    chk("ext_count_wrap", OUT_W'(ext_count), 0);
    chk("neg_count_keep", OUT_W'(neg_count), 4);
`endif

    chk("scoreboard_empty", OUT_W'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the 32-bit MIPS datapath.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes:
  - zero-extend
  - sign-extend
  - upper (LUI placement)
  - branch offset (sign-extend, then shift left 2)
- Sits between decode and the ALU/branch-target operand mux.
- Valid/ready handshake with a one-entry skid buffer, so decode stalls never lose an immediate.

Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: extended output width. Constraint OUT_W >= IN_W+2; the bench checks this at elaboration.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_imm/in_mode are valid.
- in_ready, output, 1: unit can accept. Driven directly from a flop.
- in_imm, input, IN_W: raw immediate.
- in_mode, input, 2: extension mode. 00 zero, 01 sign, 10 upper, 11 branch.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts out_data.
- out_data, output, OUT_W: extended result.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-transfer):
  - out_valid=0, out_data=0, in_ready=1.
  - Skid entry emptied; any held data is discarded.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Extension is combinational on the input side. Results are registered; stored data is already extended.
  - Mode 00: {(OUT_W-IN_W) zeros, in_imm}.
  - Mode 01: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - Mode 10: in_imm placed at bits [OUT_W-1:OUT_W-IN_W]; lower bits zero.
  - Mode 11: sign-extend result shifted left 2, truncated to OUT_W; bits [1:0]=0.
- Latency: accepted input appears on out_data with out_valid=1 on the next rising edge, provided the output register is empty or draining that cycle.
- Storage: output register OREG plus skid register SREG. States by occupancy:
  - EMPTY: OREG and SREG empty. in_ready=1. Accept -> ONE.
  - ONE: OREG full, SREG empty. in_ready=1.
    - Accept && out_ready: OREG loads new result; stay ONE.
    - Accept && !out_ready: SREG loads new result -> FULL.
    - No accept && out_ready -> EMPTY.
  - FULL: OREG and SREG full. in_ready=0.
    - out_ready: OREG<=SREG -> ONE.
    - No input is accepted while FULL.
- in_ready is a registered copy of (next state != FULL).
- Ordering is strictly FIFO; no reordering, drop or duplication.
- Simultaneous accept and drain in ONE produces a zero-bubble stream: one result per cycle sustained.
- in_mode is sampled only on an accepted transfer; changes while not accepting have no effect.
- Throughput: 1 transfer/cycle whenever out_ready is held high.

Optional Feature:
- Macro: IMM_EXT_STATS_EN.
- Defined:
  - Adds output ext_count [15:0], counting output transfers.
  - Adds output neg_count [15:0], counting transfers whose mode-01/11 input had in_imm[IN_W-1]=1.
  - Both counters wrap at 16'hFFFF -> 0 and reset to 0.
  - Both update on the same edge as the output transfer.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset: assert reset asynchronously between edges -> out_valid=0, out_data=0x00000000, in_ready=1 immediately. Release reset, hold in_valid=0 for 5 cycles -> out_valid stays 0.
- Modes, with out_ready=1:
  - mode 00, 0x8001 -> 0x00008001 one cycle later.
  - mode 01, 0x8001 -> 0xFFFF8001.
  - mode 01, 0x7FFF -> 0x00007FFF.
  - mode 10, 0x1234 -> 0x12340000.
  - mode 11, 0xFFFF -> 0xFFFFFFFC.
  - mode 11, 0x0004 -> 0x00000010.
- Backpressure: out_ready=0; offer 0x0001, 0x0002, 0x0003 in mode 00 -> first two accepted, in_ready=0 from the third cycle, 0x0003 held by the source. Raise out_ready -> outputs 0x00000001, 0x00000002, 0x00000003 in order, no gaps after the first.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with increasing values -> 8 consecutive out_valid cycles, 1-cycle latency, in_ready never drops.
- Reset mid-operation: fill to FULL, assert reset -> out_valid=0, in_ready=1. After release, the next input 0x00FF in mode 00 produces 0x000000FF with no stale data ahead of it.
- With IMM_EXT_STATS_EN defined:
  - Four mode-01 transfers of 0x8000 -> ext_count=4, neg_count=4.
  - Preload 0xFFFF transfers and do one more -> ext_count wraps to 0.
